// File: rtl/mlp_acc_pkg.sv
// Shared types and default sizes for the MLP result buffer slice.
package mlp_acc_pkg;

    localparam int DEF_N              = 16;
    localparam int DEF_DW             = 16;
    localparam int DEF_ROWS_PER_ROUND = 2;
    localparam int DEF_OUT_W          = 32;

    typedef logic signed [DEF_DW-1:0] elem_t;
    typedef elem_t [DEF_N-1:0]        row_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } buf_state_e;

    // Observation struct: FSM state plus bank bookkeeping.
    typedef struct packed {
        buf_state_e state;
        logic       wr_bank;
        logic       fb_bank;
        logic       fb_bank_valid;
    } buf_dbg_t;

endpackage

// File: rtl/mlp_result_buffer_if.sv
// Result stream interface of the MLP result buffer.
// Handshake: a beat transfers on a rising clk edge where result_valid and
// result_ready are both 1. Once result_valid is raised, result_payload and
// result_last stay stable until that transfer; result_valid never depends
// combinationally on result_ready.
interface mlp_result_buffer_if
    import mlp_acc_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W
) ();
    logic             result_valid;
    logic             result_ready;
    logic [OUT_W-1:0] result_payload;
    logic             result_last;

    modport master (
        output result_valid,
        output result_payload,
        output result_last,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_payload,
        input  result_last,
        output result_ready
    );
endinterface

// File: rtl/mlp_result_bank.sv
// One storage bank of the result buffer: round-granular write port, one
// registered full-row read port (feedback) and a combinational beat read
// port (drain). Contents are deliberately not reset.
module mlp_result_bank
    import mlp_acc_pkg::*;
#(
    parameter int N              = DEF_N,
    parameter int DW             = DEF_DW,
    parameter int ROWS_PER_ROUND = DEF_ROWS_PER_ROUND,
    parameter int OUT_W          = DEF_OUT_W
) (
    input  logic                                   clk,
    input  logic                                   wr_en,
    input  logic [$clog2(N/ROWS_PER_ROUND)-1:0]    wr_round,
    input  logic [ROWS_PER_ROUND*N*DW-1:0]         wr_data,
    input  logic                                   rd_en,
    input  logic [$clog2(N)-1:0]                   rd_row,
    output logic [N*DW-1:0]                        rd_data,
    input  logic [$clog2(N*N*DW/OUT_W)-1:0]        beat,
    output logic [OUT_W-1:0]                       beat_data
);
    localparam int NW  = $clog2(N);
    localparam int BPR = N*DW/OUT_W;   // beats per row

    logic [N*DW-1:0] mem [N];
    logic [NW-1:0]   beat_row;
    int              beat_off;

    // Store all rows of one round at rows wr_round*ROWS_PER_ROUND upward.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int r = 0; r < ROWS_PER_ROUND; r++) begin
                mem[NW'(int'(wr_round) * ROWS_PER_ROUND + r)] <= wr_data[r*N*DW +: N*DW];
            end
        end
    end

    // Registered feedback row read.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_row];
        end
    end

    // Row-major beat selection: beat k holds elements k*P .. k*P+P-1.
    always_comb begin
        beat_row  = NW'(int'(beat) / BPR);
        beat_off  = int'(beat) % BPR;
        beat_data = mem[beat_row][beat_off*OUT_W +: OUT_W];
    end

endmodule

// File: rtl/mlp_result_buffer.sv
// Double-buffered MLP layer result store. Collects an N x N layer result
// round by round, then either hands the bank to the array as feedback
// (ping-pong) or drains it over the valid/ready result stream.
// Optional build macro: MLP_RESULT_RELU_EN clamps negative elements to zero
// on the feedback path only.
module mlp_result_buffer
    import mlp_acc_pkg::*;
#(
    parameter int N              = DEF_N,
    parameter int DW             = DEF_DW,
    parameter int ROWS_PER_ROUND = DEF_ROWS_PER_ROUND,
    parameter int OUT_W          = DEF_OUT_W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_valid_i,
    input  logic [$clog2(N/ROWS_PER_ROUND)-1:0] wr_round_i,
    input  logic [ROWS_PER_ROUND*N*DW-1:0]      wr_data_i,
    input  logic                                layer_last_i,
    input  logic                                fb_req_i,
    input  logic [$clog2(N)-1:0]                fb_row_i,
    output logic [N*DW-1:0]                     fb_data_o,
    output logic                                fb_valid_o,
    mlp_result_buffer_if.master                 res,
    output logic                                busy_o,
    output logic                                err_o,
    output buf_dbg_t                            dbg_o
);
    localparam int R  = N/ROWS_PER_ROUND;
    localparam int B  = N*N*DW/OUT_W;
    localparam int BW = $clog2(B);

    buf_state_e       state_q, state_d;
    logic             wr_bank_q, fb_bank_q, fb_bank_valid_q;
    logic [R-1:0]     mask_q, mask_set;
    logic             last_q;
    logic [BW-1:0]    beat_q;
    logic             res_valid_q, res_last_q;
    logic [OUT_W-1:0] res_payload_q;
    logic             fb_valid_q, fb_sel_q, err_q;

    logic             do_write, complete, to_drain, load_beat, drain_done, drop;
    logic [N*DW-1:0]  rd_data0, rd_data1, fb_row_sel;
    logic [OUT_W-1:0] beat_data0, beat_data1, drain_word;

    // Mask as it would look after accepting the current write.
    always_comb begin
        mask_set             = mask_q;
        mask_set[wr_round_i] = 1'b1;
    end

    // Next-state and control decode.
    always_comb begin
        state_d    = state_q;
        do_write   = 1'b0;
        complete   = 1'b0;
        to_drain   = 1'b0;
        load_beat  = 1'b0;
        drain_done = 1'b0;
        drop       = 1'b0;
        case (state_q)
            IDLE, FILL: begin
                if (wr_valid_i) begin
                    do_write = 1'b1;
                    if (&mask_set) begin
                        complete = 1'b1;
                        if (last_q || layer_last_i) begin
                            to_drain = 1'b1;
                            state_d  = DRAIN;
                        end else begin
                            state_d  = IDLE;
                        end
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            DRAIN: begin
                drop = wr_valid_i;
                // The output register may change when empty or being accepted.
                if (!res_valid_q || res.result_ready) begin
                    if (res_valid_q && res_last_q) begin
                        drain_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        load_beat = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, bank bookkeeping, output stream and feedback registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            wr_bank_q       <= 1'b0;
            fb_bank_q       <= 1'b0;
            fb_bank_valid_q <= 1'b0;
            mask_q          <= '0;
            last_q          <= 1'b0;
            beat_q          <= '0;
            res_valid_q     <= 1'b0;
            res_last_q      <= 1'b0;
            res_payload_q   <= '0;
            fb_valid_q      <= 1'b0;
            fb_sel_q        <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= drop;
            fb_valid_q <= fb_req_i && fb_bank_valid_q;
            fb_sel_q   <= fb_bank_q;
            if (do_write) begin
                mask_q <= mask_set;
                last_q <= last_q | layer_last_i;
            end
            if (complete) begin
                if (to_drain) begin
                    beat_q <= '0;
                end else begin
                    // Hand the finished bank to the array; fill the other one next.
                    mask_q          <= '0;
                    last_q          <= 1'b0;
                    fb_bank_q       <= wr_bank_q;
                    fb_bank_valid_q <= 1'b1;
                    wr_bank_q       <= ~wr_bank_q;
                end
            end
            if (load_beat) begin
                res_valid_q   <= 1'b1;
                res_payload_q <= drain_word;
                res_last_q    <= (beat_q == BW'(B-1));
                beat_q        <= beat_q + BW'(1);
            end
            if (drain_done) begin
                res_valid_q     <= 1'b0;
                res_last_q      <= 1'b0;
                mask_q          <= '0;
                last_q          <= 1'b0;
                fb_bank_valid_q <= 1'b0;
            end
        end
    end

    mlp_result_bank #(
        .N(N), .DW(DW), .ROWS_PER_ROUND(ROWS_PER_ROUND), .OUT_W(OUT_W)
    ) u_bank0 (
        .clk       (clk),
        .wr_en     (do_write && !wr_bank_q),
        .wr_round  (wr_round_i),
        .wr_data   (wr_data_i),
        .rd_en     (fb_req_i && fb_bank_valid_q && !fb_bank_q),
        .rd_row    (fb_row_i),
        .rd_data   (rd_data0),
        .beat      (beat_q),
        .beat_data (beat_data0)
    );

    mlp_result_bank #(
        .N(N), .DW(DW), .ROWS_PER_ROUND(ROWS_PER_ROUND), .OUT_W(OUT_W)
    ) u_bank1 (
        .clk       (clk),
        .wr_en     (do_write && wr_bank_q),
        .wr_round  (wr_round_i),
        .wr_data   (wr_data_i),
        .rd_en     (fb_req_i && fb_bank_valid_q && fb_bank_q),
        .rd_row    (fb_row_i),
        .rd_data   (rd_data1),
        .beat      (beat_q),
        .beat_data (beat_data1)
    );

    // Drain always reads the bank that was just filled.
    assign drain_word = wr_bank_q ? beat_data1 : beat_data0;
    assign fb_row_sel = fb_sel_q ? rd_data1 : rd_data0;

    // Feedback output: zero unless a valid read was issued last cycle.
    always_comb begin
        fb_data_o = '0;
        if (fb_valid_q) begin
`ifdef MLP_RESULT_RELU_EN
            for (int c = 0; c < N; c++) begin
                fb_data_o[c*DW +: DW] = fb_row_sel[c*DW+DW-1] ? '0 : fb_row_sel[c*DW +: DW];
            end
`else
            fb_data_o = fb_row_sel;
`endif
        end
    end

    assign fb_valid_o         = fb_valid_q;
    assign res.result_valid   = res_valid_q;
    assign res.result_payload = res_payload_q;
    assign res.result_last    = res_last_q;
    assign busy_o             = (state_q != IDLE);
    assign err_o              = err_q;
    assign dbg_o              = '{state: state_q, wr_bank: wr_bank_q,
                                  fb_bank: fb_bank_q, fb_bank_valid: fb_bank_valid_q};

endmodule

// File: tb/tb_mlp_result_buffer.sv
// Self-checking bench for mlp_result_buffer with a matrix-level reference model.
`timescale 1ns/1ps
module tb_mlp_result_buffer;
    import mlp_acc_pkg::*;

    localparam int N     = 16;
    localparam int DW    = 16;
    localparam int RPR   = 2;
    localparam int OUT_W = 32;
    localparam int R     = N/RPR;
    localparam int P     = OUT_W/DW;
    localparam int B     = N*N*DW/OUT_W;
    localparam int RW    = $clog2(R);
    localparam int NW    = $clog2(N);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                   wr_valid_i = 1'b0;
    logic [RW-1:0]          wr_round_i = '0;
    logic [RPR*N*DW-1:0]    wr_data_i = '0;
    logic                   layer_last_i = 1'b0;
    logic                   fb_req_i = 1'b0;
    logic [NW-1:0]          fb_row_i = '0;
    logic [N*DW-1:0]        fb_data_o;
    logic                   fb_valid_o, busy_o, err_o;
    buf_dbg_t               dbg_o;

    mlp_result_buffer_if #(.OUT_W(OUT_W)) res();

    mlp_result_buffer #(
        .N(N), .DW(DW), .ROWS_PER_ROUND(RPR), .OUT_W(OUT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid_i   (wr_valid_i),
        .wr_round_i   (wr_round_i),
        .wr_data_i    (wr_data_i),
        .layer_last_i (layer_last_i),
        .fb_req_i     (fb_req_i),
        .fb_row_i     (fb_row_i),
        .fb_data_o    (fb_data_o),
        .fb_valid_o   (fb_valid_o),
        .res          (res),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .dbg_o        (dbg_o)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] src   [N][N];      // layer being written
    logic [DW-1:0] m_mat [2][N][N];   // expected bank contents
    int  m_wr_bank = 0, m_fb_bank = 0, m_drain_bank = 0;
    bit  m_fb_valid = 0, m_last = 0;
    bit  m_seen [R];
    int  tests = 0, fails = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*DW-1:0] exp_fb_row(input int bank, input int row);
        logic [N*DW-1:0] v;
        logic [DW-1:0]   e;
        for (int c = 0; c < N; c++) begin
            e = m_mat[bank][row][c];
`ifdef MLP_RESULT_RELU_EN
            if (e[DW-1]) e = '0;
`endif
            v[c*DW +: DW] = e;
        end
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] exp_beat(input int bank, input int k);
        logic [OUT_W-1:0] v;
        int idx;
        for (int p = 0; p < P; p++) begin
            idx = k*P + p;
            v[p*DW +: DW] = m_mat[bank][idx/N][idx%N];
        end
        return v;
    endfunction

    // A layer is complete once every round index has been seen at least once.
    task automatic model_write(input int rnd, input bit lst);
        bit all_seen;
        for (int r = 0; r < RPR; r++)
            for (int c = 0; c < N; c++)
                m_mat[m_wr_bank][rnd*RPR + r][c] = src[rnd*RPR + r][c];
        m_seen[rnd] = 1'b1;
        m_last = m_last | lst;
        all_seen = 1'b1;
        for (int i = 0; i < R; i++) all_seen = all_seen & m_seen[i];
        if (all_seen) begin
            for (int i = 0; i < R; i++) m_seen[i] = 1'b0;
            if (m_last) begin
                m_drain_bank = m_wr_bank;
            end else begin
                m_fb_bank  = m_wr_bank;
                m_fb_valid = 1'b1;
                m_wr_bank  = 1 - m_wr_bank;
            end
            m_last = 1'b0;
        end
    endtask

    task automatic set_idx();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                src[r][c] = DW'(r*N + c);
    endtask

    task automatic set_rand();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                src[r][c] = DW'($urandom);
    endtask

    // ---------------- driver tasks ----------------
    // One clock with optional round write and optional feedback request.
    task automatic step(input bit wv, input int rnd, input bit lst, input bit req, input int row);
        logic            exp_v;
        logic [N*DW-1:0] exp_d;
        exp_v = req && m_fb_valid;
        exp_d = exp_v ? exp_fb_row(m_fb_bank, row) : '0;
        wr_valid_i   = wv;
        wr_round_i   = RW'(rnd);
        layer_last_i = lst;
        for (int r = 0; r < RPR; r++)
            for (int c = 0; c < N; c++)
                wr_data_i[(r*N + c)*DW +: DW] = src[rnd*RPR + r][c];
        fb_req_i = req;
        fb_row_i = NW'(row);
        tick();
        wr_valid_i   = 1'b0;
        layer_last_i = 1'b0;
        fb_req_i     = 1'b0;
        if (wv) model_write(rnd, lst);
        if (req) begin
            check("fb_valid", fb_valid_o, exp_v);
            check("fb_data", fb_data_o, exp_d);
        end
        check("err_fill", err_o, 1'b0);
    endtask

    task automatic sweep();
        for (int i = 0; i < N; i++) step(1'b0, 0, 1'b0, 1'b1, $urandom_range(N-1));
    endtask

    // Writes all rounds in random order with random concurrent feedback reads.
    task automatic fill_layer(input bit lst_all, input int lst_round);
        int order [R];
        int j, t;
        for (int i = 0; i < R; i++) order[i] = i;
        for (int i = R-1; i > 0; i--) begin
            j = $urandom_range(i);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < R; i++)
            step(1'b1, order[i], lst_all || (order[i] == lst_round), 1'b1, $urandom_range(N-1));
    endtask

    // Scoreboard for one drain: beats are expected in order from an expected queue.
    task automatic drain(input int stall_beat, input int stall_n, input bit rand_ready,
                         input int err_beat, input int abort_beat, input bit idx_pat);
        logic [OUT_W-1:0] exp_q [$];
        int  k = 0, cyc = 0, stall_left = stall_n, err_cnt = 0, bubbles = 0;
        bit  seen_first = 0, injected = 0;
        for (int i = 0; i < B; i++) exp_q.push_back(exp_beat(m_drain_bank, i));
        check("drain_busy", busy_o, 1'b1);
        check("drain_state", dbg_o.state, DRAIN);
        while (k < B && cyc < 4000) begin
            if (err_o) err_cnt++;
            if (res.result_valid) begin
                seen_first = 1'b1;
                if (k == abort_beat) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_res_valid", res.result_valid, 1'b0);
                    check("rst_res_payload", res.result_payload, '0);
                    check("rst_busy", busy_o, 1'b0);
                    tick(); tick();
                    rst_n = 1'b1;
                    tick();
                    m_wr_bank = 0; m_fb_bank = 0; m_fb_valid = 0; m_last = 0;
                    for (int i = 0; i < R; i++) m_seen[i] = 1'b0;
                    check("post_rst_state", dbg_o.state, IDLE);
                    check("post_rst_wr_bank", dbg_o.wr_bank, 1'b0);
                    check("post_rst_fbv", dbg_o.fb_bank_valid, 1'b0);
                    check("post_rst_fb_valid", fb_valid_o, 1'b0);
                    check("post_rst_res_valid", res.result_valid, 1'b0);
                    step(1'b0, 0, 1'b0, 1'b1, 3);
                    return;
                end
                check("payload", res.result_payload, exp_q[0]);
                check("last", res.result_last, k == B-1);
                if (idx_pat && k == 0)   check("beat0", res.result_payload, 32'h0001_0000);
                if (idx_pat && k == 10)  check("beat10", res.result_payload, 32'h0015_0014);
                if (idx_pat && k == B-1) check("beat_last", res.result_payload, 32'h00FF_00FE);
                if (k == stall_beat && stall_left > 0) begin
                    res.result_ready = 1'b0;
                    stall_left--;
                end else if (rand_ready && $urandom_range(3) == 0) begin
                    res.result_ready = 1'b0;
                end else begin
                    res.result_ready = 1'b1;
                    void'(exp_q.pop_front());
                    k++;
                end
            end else begin
                if (seen_first) bubbles++;
                res.result_ready = 1'($urandom_range(1));
            end
            if (k == err_beat && !injected) begin
                injected     = 1'b1;
                wr_valid_i   = 1'b1;
                wr_round_i   = RW'($urandom_range(R-1));
                wr_data_i    = {(RPR*N*DW/32){$urandom}};
                layer_last_i = 1'b0;
            end
            tick();
            wr_valid_i = 1'b0;
            cyc++;
        end
        check("drain_beats", k, B);
        check("drain_bubbles", bubbles, 0);
        check("err_pulses", err_cnt, (err_beat >= 0) ? 1 : 0);
        check("end_res_valid", res.result_valid, 1'b0);
        check("end_res_last", res.result_last, 1'b0);
        check("end_busy", busy_o, 1'b0);
        check("end_state", dbg_o.state, IDLE);
        check("end_fbv", dbg_o.fb_bank_valid, 1'b0);
        m_fb_valid = 1'b0;
        res.result_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [DW-1:0] relu_exp;
        res.result_ready = 1'b0;
        for (int i = 0; i < R; i++) m_seen[i] = 1'b0;
        tick(); tick();
        check("rst_state", dbg_o.state, IDLE);
        check("rst_wr_bank", dbg_o.wr_bank, 1'b0);
        check("rst_fbv", dbg_o.fb_bank_valid, 1'b0);
        check("rst_res_valid", res.result_valid, 1'b0);
        check("rst_res_last", res.result_last, 1'b0);
        check("rst_payload", res.result_payload, '0);
        check("rst_fb_valid", fb_valid_o, 1'b0);
        check("rst_fb_data", fb_data_o, '0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        rst_n = 1'b1;
        tick();

        // Feedback request with no bank available.
        step(1'b0, 0, 1'b0, 1'b1, 5);

        // Layer A: hidden layer, index pattern, in-order rounds.
        set_idx();
        for (int i = 0; i < R; i++) step(1'b1, i, 1'b0, 1'b0, 0);
        check("a_state", dbg_o.state, IDLE);
        check("a_fbv", dbg_o.fb_bank_valid, 1'b1);
        check("a_wr_bank", dbg_o.wr_bank, 1'b1);
        check("a_fb_bank", dbg_o.fb_bank, 1'b0);
        check("a_busy", busy_o, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1, 3);
        check("a_r3c5", fb_data_o[5*DW +: DW], 16'h0035);
        sweep();

        // Layer B: random data, duplicate round 2, concurrent reads of bank 0.
        set_rand();
        src[0][0] = 16'hFFF0;
        step(1'b1, 0, 1'b0, 1'b1, $urandom_range(N-1));
        step(1'b1, 1, 1'b0, 1'b1, $urandom_range(N-1));
        step(1'b1, 2, 1'b0, 1'b1, $urandom_range(N-1));
        step(1'b1, 3, 1'b0, 1'b1, $urandom_range(N-1));
        for (int c = 0; c < N; c++) begin
            src[4][c] = DW'($urandom);
            src[5][c] = DW'($urandom);
        end
        step(1'b1, 2, 1'b0, 1'b1, $urandom_range(N-1));
        for (int i = 4; i < 7; i++) step(1'b1, i, 1'b0, 1'b1, $urandom_range(N-1));
        check("b_not_done_state", dbg_o.state, FILL);
        check("b_not_done_wr_bank", dbg_o.wr_bank, 1'b1);
        check("b_not_done_fb_bank", dbg_o.fb_bank, 1'b0);
        check("b_busy", busy_o, 1'b1);
        // Completion with a simultaneous read: served from the old bank.
        step(1'b1, 7, 1'b0, 1'b1, $urandom_range(N-1));
        check("b_wr_bank", dbg_o.wr_bank, 1'b0);
        check("b_fb_bank", dbg_o.fb_bank, 1'b1);
        check("b_state", dbg_o.state, IDLE);
        step(1'b0, 0, 1'b0, 1'b1, 0);
`ifdef MLP_RESULT_RELU_EN
        relu_exp = 16'h0000;
`else
        relu_exp = 16'hFFF0;
`endif
        check("b_r0c0", fb_data_o[DW-1:0], relu_exp);
        step(1'b0, 0, 1'b0, 1'b1, 4);
        step(1'b0, 0, 1'b0, 1'b1, 5);
        sweep();

        // Layer C: output layer, ready held high.
        set_idx();
        fill_layer(1'b1, -1);
        res.result_ready = 1'b1;
        drain(-1, 0, 1'b0, -1, -1, 1'b1);

        // Layer D: last flag on one round only, stall on beat 10, write during drain.
        set_idx();
        fill_layer(1'b0, 5);
        drain(10, 5, 1'b1, 20, -1, 1'b1);

        // Layer E: random output layer, reset asserted mid-drain.
        set_rand();
        fill_layer(1'b1, -1);
        drain(-1, 0, 1'b1, -1, 40, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mlp_result_buffer.md
Name: mlp_result_buffer

Overview:
Parametrised, double-buffered result store that sits between the PE array round outputs and both the array input mux (layer feedback) and the serial result port.
- Collects one full N x N layer result, ROWS_PER_ROUND rows per PE-array round.
- On layer completion, either hands the bank to the array as the next layer's input (ping-pong) or drains it over a valid/ready 32-bit output stream.
- Replaces the fixed 16x16 out_reg / shift-out logic; adds backpressure, a last flag, bank ping-pong and error reporting.

Parameters:
N, 16, matrix dimension (rows = cols); power of two, >= ROWS_PER_ROUND
DW, 16, element width in bits (two's complement)
ROWS_PER_ROUND, 2, rows produced per PE-array round; divides N
OUT_W, 32, result payload width; multiple of DW, divides N*DW

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_valid_i  in  1  round result valid from PE array
wr_round_i  in  $clog2(N/ROWS_PER_ROUND)  round index; rows wr_round_i*ROWS_PER_ROUND upward
wr_data_i  in  ROWS_PER_ROUND*N*DW  round rows; row r, col c at bits [(r*N+c)*DW +: DW]
layer_last_i  in  1  sampled with each write; 1 = this layer is the output layer
fb_req_i  in  1  feedback row read request
fb_row_i  in  $clog2(N)  feedback row index
fb_data_o  out  N*DW  feedback row; col c at [c*DW +: DW]
fb_valid_o  out  1  fb_data_o valid
result_valid_o  out  1  output beat valid
result_ready_i  in  1  output beat accepted
result_payload_o  out  OUT_W  packed elements; lowest element in lowest bits
result_last_o  out  1  final beat of the matrix
busy_o  out  1  state != IDLE
err_o  out  1  one-cycle pulse: write dropped

Behaviour:
- Reset (async, rst_n=0): state IDLE; wr_bank=0; fb_bank_valid=0; round mask cleared. All outputs 0. Bank contents are not reset.
- R = N/ROWS_PER_ROUND rounds per layer. A per-round mask tracks which rounds have been written into wr_bank.
- FSM states:
  - IDLE -> FILL on the first wr_valid_i.
  - FILL: each wr_valid_i writes its round into wr_bank and sets the mask bit. A repeated round overwrites the data without a second count. layer_last_i is latched as OR over the layer's writes.
  - Completion: the cycle the mask becomes all-ones.
    - If layer_last was latched -> DRAIN on wr_bank.
    - Otherwise: fb_bank <= wr_bank, fb_bank_valid <= 1, wr_bank toggles, mask clears, -> IDLE.
  - DRAIN: beats B = N*N*DW/OUT_W, row-major order. Beat k carries elements k*P .. k*P+P-1, where P = OUT_W/DW.
    - result_valid_o is registered and held with stable payload until result_ready_i.
    - result_last_o = 1 on beat B-1 only.
    - After the handshake on beat B-1: clear mask and fb_bank_valid, -> IDLE. The next cycle result_valid_o = 0.
- wr_valid_i while in DRAIN: data dropped, err_o pulses for 1 cycle, state unchanged.
- Feedback:
  - fb_req_i with fb_bank_valid=1: fb_data_o is the row of fb_bank, fb_valid_o=1 the following cycle (1-cycle latency, one request per cycle, full throughput).
  - fb_req_i with fb_bank_valid=0: fb_valid_o=0, fb_data_o=0.
  - Feedback reads and FILL writes to the other bank may occur in the same cycle.
- A completion that toggles the bank in the same cycle as fb_req_i is served from the old fb_bank.
- Default widths (N=16, DW=16, OUT_W=32): B=128 beats; first beat = {row0col1, row0col0}.

Optional Feature:
- MLP_RESULT_RELU_EN defined: on the feedback path only, any element with sign bit set is replaced by 0 in fb_data_o. The drain path is unaffected.
- Undefined: fb_data_o carries stored values unchanged.

Decomposition:
- Package mlp_acc_pkg holds:
  - default N, DW, ROWS_PER_ROUND, OUT_W localparams;
  - typedefs elem_t (logic signed [DW-1:0]) and row_t (elem_t [N-1:0]);
  - enum buf_state_e {IDLE, FILL, DRAIN}.
- Sub-module mlp_result_bank, instantiated twice:
  - one bank's storage;
  - round-write port;
  - row-read port with registered output;
  - element-pair read port for drain.

Test Plan:
- Layer not last: 8 rounds, element value = row*16+col -> after round 7, fb_bank_valid=1; fb_req row 3 -> next cycle fb_data_o col 5 = 0x0035; wr_bank=1.
- Output layer: 8 rounds with layer_last_i=1, ready tied high -> 128 consecutive beats; beat 0 = 0x00010000, beat 127 = 0x00FF00FE with result_last_o=1; busy_o falls after.
- Backpressure: ready low for 5 cycles on beat 10 -> payload 0x00150014 held stable, no beat lost or repeated; total beats still 128.
- Write during DRAIN -> err_o pulses exactly 1 cycle, drained data unchanged.
- Duplicate round 2 before round 7 -> completion only after all 8 distinct rounds; round 2 holds the second data.
- Assert rst_n mid-drain at beat 40 -> result_valid_o=0 immediately; after release state IDLE, fb_valid_o=0. With MLP_RESULT_RELU_EN, stored 0xFFF0 reads back 0x0000 on feedback.
